seg_display_ctrl: RTL and testbench

SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

---
 rtl/seg_display_ctrl_pkg.sv | 23 ++
 rtl/seg_display_ctrl_seg7_decoder.sv | 28 ++
 rtl/seg_display_ctrl.sv | 109 ++++++++++
 tb/tb_seg_display_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_display_ctrl_pkg.sv
// Shared nibble codes and active-low segment patterns ({g,f,e,d,c,b,a}) for the
// multiplexed seven-segment display controller.
package seg_display_ctrl_pkg;

    localparam logic [3:0] CODE_DASH  = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hE;
    localparam logic [3:0] CODE_ERR   = 4'hF;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_ERR   = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg_display_ctrl_seg7_decoder.sv
// Purely combinational nibble-code to active-low seven-segment decode.
module seg7_decoder
    import seg_display_ctrl_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'h0:      seg = SEG_0;
            4'h1:      seg = SEG_1;
            4'h2:      seg = SEG_2;
            4'h3:      seg = SEG_3;
            4'h4:      seg = SEG_4;
            4'h5:      seg = SEG_5;
            4'h6:      seg = SEG_6;
            4'h7:      seg = SEG_7;
            4'h8:      seg = SEG_8;
            4'h9:      seg = SEG_9;
            CODE_DASH: seg = SEG_DASH;
            CODE_ERR:  seg = SEG_ERR;
            default:   seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_display_ctrl.sv
// Byte-fed multiplexed seven-segment controller: shadow buffer filled from a UART
// receiver, display buffer snapshotted once per frame, dead-time blanking per slot.
module seg_display_ctrl
    import seg_display_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 16,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  rx_perror,
    input  logic                  rx_ferror,
    output logic [NUM_DIGITS-1:0] anodes,
    output logic [6:0]            led_out,
    output logic                  frame_start
);

    localparam int BUF_W  = NUM_DIGITS * 4;
    localparam int SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W  = $clog2(NUM_DIGITS);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_DEAD = SLOT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BUF_W-1:0]  BUF_BLANK = {NUM_DIGITS{CODE_BLANK}};
    localparam logic [BUF_W-1:0]  BUF_ERR   = {NUM_DIGITS{CODE_ERR}};

    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BUF_W-1:0]      shadow_q, shadow_d;
    logic [BUF_W-1:0]      disp_q, disp_d;
    logic [NUM_DIGITS-1:0] anodes_q, anodes_d;
    logic [6:0]            led_q, led_d;
    logic                  frame_start_q, frame_start_d;

    logic       frame_edge;
    logic [3:0] cur_code;
    logic [6:0] cur_seg;

    // The counters name the slot whose outputs are registered on the next edge,
    // so the snapshot is taken on the same edge that raises frame_start. A byte
    // sampled on that edge is in the snapshot; one arriving during the
    // frame_start cycle lands on the following edge and waits a frame.
    always_comb begin
        slot_d = slot_q + 1'b1;
        idx_d  = idx_q;
        if (slot_q == SLOT_LAST) begin
            slot_d = '0;
            idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        frame_edge = (slot_q == '0) && (idx_q == '0);

        shadow_d = shadow_q;
        if (rx_perror || rx_ferror) begin
            shadow_d = BUF_ERR;
        end else if (rx_valid) begin
            shadow_d      = shadow_q << 8;
            shadow_d[7:0] = rx_data;
        end

        disp_d   = frame_edge ? shadow_d : disp_q;
        cur_code = disp_d[{idx_q, 2'b00} +: 4];
    end

    seg7_decoder u_decoder (
        .code (cur_code),
        .seg  (cur_seg)
    );

    // Blank codes keep their anode off too, so an empty display never strobes.
    always_comb begin
        anodes_d      = '1;
        led_d         = SEG_BLANK;
        frame_start_d = frame_edge;
        if ((slot_q >= SLOT_DEAD) && (cur_seg != SEG_BLANK)) begin
            anodes_d[idx_q] = 1'b0;
            led_d           = cur_seg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q        <= '0;
            idx_q         <= '0;
            shadow_q      <= BUF_BLANK;
            disp_q        <= BUF_BLANK;
            anodes_q      <= '1;
            led_q         <= SEG_BLANK;
            frame_start_q <= 1'b0;
        end else begin
            slot_q        <= slot_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            disp_q        <= disp_d;
            anodes_q      <= anodes_d;
            led_q         <= led_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign anodes      = anodes_q;
    assign led_out     = led_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Scoreboard bench: stimulus queues the expected digit patterns of each frame,
// a monitor checks every cycle of every frame plus reset blanking.
module tb_seg_display_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_perror = 1'b0;
    logic       rx_ferror = 1'b0;
    logic [3:0] anodes;
    logic [6:0] led_out;
    logic       frame_start;

    int errors = 0;
    int checks = 0;
    bit done = 1'b0;

    logic [27:0] exp_q[$];

    seg_display_ctrl #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (16),
        .DEAD_CYCLES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_perror   (rx_perror),
        .rx_ferror   (rx_ferror),
        .anodes      (anodes),
        .led_out     (led_out),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0111111;
            4'hF: return 7'b0001110;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [27:0] mk(input logic [3:0] d3, input logic [3:0] d2,
                                       input logic [3:0] d1, input logic [3:0] d0);
        return {seg(d3), seg(d2), seg(d1), seg(d0)};
    endfunction

    task automatic send(input logic [7:0] d, input logic v, input logic pe, input logic fe);
        rx_data   = d;
        rx_valid  = v;
        rx_perror = pe;
        rx_ferror = fe;
        @(posedge clk);
        #1;
        rx_valid  = 1'b0;
        rx_perror = 1'b0;
        rx_ferror = 1'b0;
        rx_data   = 8'h00;
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 200);
        if (!frame_start) begin
            $display("FAIL wait_frame_start: no frame_start within %0d cycles, required one per 64", n);
            $fatal(1, "frame_start timeout");
        end
    endtask

    // Stimulus: frame k's expectation is pushed during frame k-1.
    initial begin
        exp_q.push_back(mk(4'hE, 4'hE, 4'hE, 4'hE));          // F0 idle
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        wait_fs();                                            // F0
        exp_q.push_back(mk(4'hE, 4'hE, 4'hE, 4'hE));          // F1 idle
        wait_fs();                                            // F1
        repeat (10) @(negedge clk);
        send(8'hA1, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(mk(4'hE, 4'hE, 4'hA, 4'h1));          // F2
        wait_fs();                                            // F2
        repeat (5) @(negedge clk);
        send(8'hA1, 1'b1, 1'b0, 1'b0);
        repeat (15) @(negedge clk);
        send(8'h94, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(mk(4'hA, 4'h1, 4'h9, 4'h4));          // F3
        wait_fs();                                            // F3
        repeat (30) @(negedge clk);
        send(8'h55, 1'b1, 1'b0, 1'b1);
        exp_q.push_back(mk(4'hF, 4'hF, 4'hF, 4'hF));          // F4
        wait_fs();                                            // F4: byte on the frame_start cycle
        exp_q.push_back(mk(4'hF, 4'hF, 4'h1, 4'h2));          // F5
        send(8'h12, 1'b1, 1'b0, 1'b0);
        wait_fs();                                            // F5: byte on the last cycle
        exp_q.push_back(mk(4'h1, 4'h2, 4'h3, 4'hE));          // F6
        repeat (63) @(negedge clk);
        send(8'h3E, 1'b1, 1'b0, 1'b0);
        wait_fs();                                            // F6
        repeat (40) @(negedge clk);
        send(8'h00, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(mk(4'hF, 4'hF, 4'hF, 4'hF));          // F7
        wait_fs();                                            // F7
        exp_q.push_back(mk(4'hF, 4'hF, 4'hF, 4'hF));          // F8, aborted by reset
        wait_fs();                                            // F8
        repeat (37) @(negedge clk);                           // digit-2 slot, lit
        #2 reset = 1'b1;
        repeat (4) @(negedge clk);
        exp_q.push_back(mk(4'hE, 4'hE, 4'hE, 4'hE));          // F9 after reset
        #1 reset = 1'b0;
        wait_fs();                                            // F9
        exp_q.push_back(mk(4'hE, 4'hE, 4'hE, 4'hE));          // F10
        wait_fs();                                            // F10
        wait_fs();                                            // F11 closes F10
        done = 1'b1;
    end

    // Monitor
    bit          in_frame = 1'b0;
    bit          prev_rst = 1'b1;
    int          cyc = 0;
    int          frame_no = 0;
    int          frames_done = 0;
    logic [27:0] cur;
    logic [3:0]  dig_err;
    logic [3:0]  act_an [4];
    logic [6:0]  act_led [4];
    logic [3:0]  req_an [4];
    logic [6:0]  req_led [4];
    int          err_cyc [4];

    task automatic check_blank();
        checks += 3;
        if (anodes !== 4'hF) begin
            errors++;
            $display("FAIL reset_anodes: anodes=%b, expected 1111", anodes);
        end
        if (led_out !== 7'h7F) begin
            errors++;
            $display("FAIL reset_led: led_out=%b, expected 1111111", led_out);
        end
        if (frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_frame_start: frame_start=%b, expected 0", frame_start);
        end
    endtask

    task automatic finalize();
        checks++;
        if (cyc != 64) begin
            errors++;
            $display("FAIL frame%0d_len: %0d cycles between frame_start pulses, expected 64", frame_no, cyc);
        end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (dig_err[d]) begin
                errors++;
                $display("FAIL frame%0d_digit%0d: anodes=%b led_out=%b at frame cycle %0d, expected anodes=%b led_out=%b",
                         frame_no, d, act_an[d], act_led[d], err_cyc[d], req_an[d], req_led[d]);
            end
        end
        frames_done++;
    endtask

    initial begin
        logic [6:0] e_seg;
        logic [3:0] e_an;
        int         slot;
        int         off;
        while (!done) begin
            @(negedge clk or posedge reset);
            if (reset) begin
                #1;
                check_blank();
                in_frame = 1'b0;
                prev_rst = 1'b1;
            end else begin
                if (prev_rst) begin
                    checks++;
                    if (frame_start !== 1'b1) begin
                        errors++;
                        $display("FAIL first_frame_start: frame_start=%b on first cycle after reset, expected 1", frame_start);
                    end
                end
                prev_rst = 1'b0;
                if (frame_start) begin
                    if (in_frame) finalize();
                    in_frame = 1'b0;
                    if (exp_q.size() > 0) begin
                        cur      = exp_q.pop_front();
                        in_frame = 1'b1;
                        cyc      = 0;
                        dig_err  = 4'b0000;
                        frame_no++;
                    end
                end
                if (in_frame) begin
                    slot = cyc / 16;
                    off  = cyc % 16;
                    if (slot < 4) begin
                        e_seg = (off < 2) ? 7'h7F : cur[slot*7 +: 7];
                        e_an  = (off < 2 || e_seg == 7'h7F) ? 4'hF : ~(4'b0001 << slot);
                        if ((anodes !== e_an || led_out !== e_seg) && !dig_err[slot]) begin
                            dig_err[slot] = 1'b1;
                            act_an[slot]  = anodes;
                            act_led[slot] = led_out;
                            req_an[slot]  = e_an;
                            req_led[slot] = e_seg;
                            err_cyc[slot] = cyc;
                        end
                    end
                    cyc++;
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drained: %0d expected frames left, expected 0", exp_q.size());
        end
        checks++;
        if (frames_done != 10) begin
            errors++;
            $display("FAIL frames_checked: %0d frames checked, expected 10", frames_done);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
